// File: rtl/capture_if.sv
// capture_if: start/stop/trigger handshake and capture status between host logic and capture_fsm
interface capture_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] trigger_loc;
    logic                  trig;
    logic [2:0]            state;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [ADDR_WIDTH-1:0] read_pointer;
    logic [ADDR_WIDTH-1:0] trigger_addr;
    logic                  done;
    modport master (
        output start, stop, trigger_loc, trig,
        input  state, bram_we, bram_addr, read_pointer, trigger_addr, done
    );
    modport slave (
        input  start, stop, trigger_loc, trig,
        output state, bram_we, bram_addr, read_pointer, trigger_addr, done
    );
endinterface

// File: rtl/capture_fsm.sv
// capture_fsm: sequences one pre/post-trigger capture into a circular sample BRAM
module capture_fsm #(
    parameter int SAMPLE_DEPTH = 4096,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input logic      clk,
    input logic      rst,
    capture_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MOVE_TO_POSITION, IN_POSITION, FILLING, CAPTURED} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
    state_t                st;
    logic [ADDR_WIDTH-1:0] addr, addr_nx, count, count_nx, loc_q, loc_d, post_q, rp, ta;
    logic                  done_q;
    always_comb begin
        loc_d    = bus.trigger_loc > LAST ? LAST : bus.trigger_loc;
        post_q   = LAST - loc_q;
        addr_nx  = addr == LAST ? '0 : addr + 1'b1;
        count_nx = count + 1'b1;
    end
    assign bus.state        = st;
    assign bus.bram_we      = st inside {MOVE_TO_POSITION, IN_POSITION, FILLING};
    assign bus.bram_addr    = addr;
    assign bus.read_pointer = rp;
    assign bus.trigger_addr = ta;
    assign bus.done         = done_q;
    // read_pointer takes the next address to be written: after a full wrap that is the oldest sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            addr   <= '0;
            count  <= '0;
            loc_q  <= '0;
            rp     <= '0;
            ta     <= '0;
            done_q <= 1'b0;
        end else if (bus.stop) begin
            st     <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (st)
                IDLE, CAPTURED: if (bus.start) begin
                    addr   <= '0;
                    count  <= '0;
                    done_q <= 1'b0;
                    loc_q  <= loc_d;
                    st     <= loc_d == '0 ? IN_POSITION : MOVE_TO_POSITION;
                end
                MOVE_TO_POSITION: begin
                    addr  <= addr_nx;
                    count <= count_nx;
                    if (count_nx == loc_q) st <= IN_POSITION;
                end
                IN_POSITION: begin
                    addr <= addr_nx;
                    if (bus.trig) begin
                        ta    <= addr;
                        count <= '0;
                        if (post_q == '0) begin
                            st     <= CAPTURED;
                            rp     <= addr_nx;
                            done_q <= 1'b1;
                        end else st <= FILLING;
                    end
                end
                FILLING: begin
                    addr  <= addr_nx;
                    count <= count_nx;
                    if (count_nx == post_q) begin
                        st     <= CAPTURED;
                        rp     <= addr_nx;
                        done_q <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_fsm.sv
// tb_capture_fsm: directed table and sequence checks of capture_fsm with an 8-deep and a 6-deep buffer
module tb_capture_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wr = 0;
    int   w0;
    always #5 clk = ~clk;

    capture_if #(.ADDR_WIDTH(3)) bus ();
    capture_if #(.ADDR_WIDTH(3)) bus6 ();
    capture_fsm #(.SAMPLE_DEPTH(8), .ADDR_WIDTH(3)) dut  (.clk(clk), .rst(rst), .bus(bus));
    capture_fsm #(.SAMPLE_DEPTH(6), .ADDR_WIDTH(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    always @(posedge clk) if (bus.bram_we) wr <= wr + 1;

    typedef struct {
        logic start;
        logic trig;
        int   loc;
        int   st;
        int   we;
        int   addr;
        int   rp;
        int   ta;
        int   done;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int st, input int we, input int addr,
                             input int rp, input int ta, input int done);
        chk({tag, ".state"}, int'(bus.state), st);
        chk({tag, ".we"}, int'(bus.bram_we), we);
        chk({tag, ".addr"}, int'(bus.bram_addr), addr);
        chk({tag, ".rp"}, int'(bus.read_pointer), rp);
        chk({tag, ".ta"}, int'(bus.trigger_addr), ta);
        chk({tag, ".done"}, int'(bus.done), done);
    endtask

    task automatic apply_table(input string tag);
        int w = wr;
        for (int i = 0; i < 10; i++) begin
            bus.start       = tbl[i].start;
            bus.trig        = tbl[i].trig;
            bus.trigger_loc = 3'(tbl[i].loc);
            check_out($sformatf("%s[%0d]", tag, i), tbl[i].st, tbl[i].we, tbl[i].addr,
                      tbl[i].rp, tbl[i].ta, tbl[i].done);
            step(1);
        end
        bus.start = 1'b0;
        bus.trig  = 1'b0;
        chk({tag, ".writes"}, wr - w, 8);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 3, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 1'b0, 3, 1, 1, 1, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 3, 1, 1, 2, 0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 3, 2, 1, 3, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 3, 3, 1, 4, 0, 3, 0};
        tbl[6] = '{1'b0, 1'b0, 3, 3, 1, 5, 0, 3, 0};
        tbl[7] = '{1'b0, 1'b0, 3, 3, 1, 6, 0, 3, 0};
        tbl[8] = '{1'b0, 1'b0, 3, 3, 1, 7, 0, 3, 0};
        tbl[9] = '{1'b0, 1'b0, 3, 4, 0, 0, 0, 3, 1};
        bus.start = 1'b0; bus.stop = 1'b0; bus.trig = 1'b0; bus.trigger_loc = '0;
        bus6.start = 1'b0; bus6.stop = 1'b0; bus6.trig = 1'b0; bus6.trigger_loc = '0;
        step(2);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1);
        apply_table("s1");

        // trig held high from start: ignored while moving to position
        bus.start = 1'b1; bus.trig = 1'b1; bus.trigger_loc = 3'd3;
        w0 = wr;
        step(1);
        bus.start = 1'b0;
        step(2);
        chk("s2.move_state", int'(bus.state), 1);
        step(1);
        chk("s2.inpos_addr", int'(bus.bram_addr), 3);
        step(1);
        chk("s2.fill_state", int'(bus.state), 3);
        step(4);
        bus.trig = 1'b0;
        check_out("s2.end", 4, 0, 0, 0, 3, 1);
        chk("s2.writes", wr - w0, 8);

        // loc=0: free-running in position, trigger after 5 writes
        bus.start = 1'b1; bus.trigger_loc = 3'd0;
        w0 = wr;
        step(1);
        bus.start = 1'b0;
        chk("s3.inpos_state", int'(bus.state), 2);
        step(5);
        chk("s3.pre_trig_addr", int'(bus.bram_addr), 5);
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        chk("s3.fill_state", int'(bus.state), 3);
        step(7);
        check_out("s3.end", 4, 0, 5, 5, 5, 1);
        chk("s3.writes", wr - w0, 13);

        // loc=7: trigger sample is the last one
        bus.start = 1'b1; bus.trigger_loc = 3'd7;
        w0 = wr;
        step(1);
        bus.start = 1'b0;
        step(7);
        chk("s4.inpos_state", int'(bus.state), 2);
        chk("s4.inpos_addr", int'(bus.bram_addr), 7);
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        check_out("s4.end", 4, 0, 0, 0, 7, 1);
        chk("s4.writes", wr - w0, 8);

        // stop clears done; stop beats simultaneous start
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check_out("s5.stop", 0, 0, 0, 0, 7, 0);
        bus.start = 1'b1; bus.stop = 1'b1; bus.trigger_loc = 3'd3;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("s5.start_stop_state", int'(bus.state), 0);
        chk("s5.start_stop_we", int'(bus.bram_we), 0);
        step(1);
        chk("s5.still_idle", int'(bus.state), 0);

        // depth 6: loc=7 clamps to 5, trigger lands on the last address
        bus6.start = 1'b1; bus6.trigger_loc = 3'd7;
        step(1);
        bus6.start = 1'b0;
        chk("s5c.move_state", int'(bus6.state), 1);
        step(5);
        chk("s5c.inpos_state", int'(bus6.state), 2);
        chk("s5c.inpos_addr", int'(bus6.bram_addr), 5);
        bus6.trig = 1'b1;
        step(1);
        bus6.trig = 1'b0;
        chk("s5c.state", int'(bus6.state), 4);
        chk("s5c.rp", int'(bus6.read_pointer), 0);
        chk("s5c.ta", int'(bus6.trigger_addr), 5);
        chk("s5c.done", int'(bus6.done), 1);
        chk("s5c.addr", int'(bus6.bram_addr), 0);

        // stop while in position
        bus.start = 1'b1; bus.trigger_loc = 3'd3;
        step(1);
        bus.start = 1'b0;
        step(3);
        chk("s6.inpos_state", int'(bus.state), 2);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        chk("s6.stop_state", int'(bus.state), 0);
        chk("s6.stop_we", int'(bus.bram_we), 0);
        chk("s6.stop_addr", int'(bus.bram_addr), 3);

        // async reset mid-filling, then a clean repeat of the first capture
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        step(1);
        chk("s6.fill_state", int'(bus.state), 3);
        chk("s6.fill_addr", int'(bus.bram_addr), 5);
        #1 rst = 1'b1;
        #1 check_out("s6.async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        apply_table("s6.rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
